// File: rtl/branch_lut_loader.sv
// branch_lut_loader: writable branch-target table.
// A boot loader streams 3-byte records (index, 12-bit signed PC offset);
// the FSM assembles them and writes the table. The fetch side reads the
// table combinationally by index.
// Optional feature macro: BRANCH_LUT_DUP_CHECK_EN (reject an index that was
// already written in the current load session).
module branch_lut_loader #(
    parameter int D     = 12,
    parameter int A     = 6,
    parameter int DEPTH = 2**A
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load_start,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic [A-1:0] addr,
    output logic [D-1:0] target,
    output logic         load_busy,
    output logic         load_done,
    output logic         load_err,
    output logic [6:0]   entry_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_IDX, S_LO, S_HI, S_DONE, S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   tbl [DEPTH];
    logic [A-1:0]   idx_q;
    logic [7:0]     lo_q;
    logic           sext_ok;
    logic           dup_hit;
    logic           wr_en;

    // upper nibble of B2 must be the sign extension of the offset's bit 11
    assign sext_ok = (byte_in[7:4] == {4{byte_in[3]}});

`ifdef BRANCH_LUT_DUP_CHECK_EN
    logic [DEPTH-1:0] wr_mask;

    // per-session record of which indices have already been written
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            wr_mask <= '0;
        else if (load_start)
            wr_mask <= '0;
        else if (wr_en)
            wr_mask[idx_q] <= 1'b1;
    end

    assign dup_hit = wr_mask[byte_in[A-1:0]];
`else
    assign dup_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // next state and state-decoded outputs; load_start overrides any transfer
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        load_err   = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDX, S_LO, S_HI: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
            end
            S_DONE: load_done = 1'b1;
            S_ERR:  load_err  = 1'b1;
            default: ;
        endcase
        if (load_start) begin
            state_d = S_IDX;
        end else if (byte_valid) begin
            case (state_q)
                S_IDX: begin
                    case (byte_in[7:6])
                        2'b01:   state_d = dup_hit ? S_ERR : S_LO;
                        2'b11:   state_d = S_DONE;
                        default: state_d = S_ERR;
                    endcase
                end
                S_LO: state_d = S_HI;
                S_HI: begin
                    state_d = sext_ok ? S_IDX : S_ERR;
                    wr_en   = sext_ok;
                end
                default: ;
            endcase
        end
        if (state_q == S_DONE && !load_start)
            state_d = S_IDLE;
    end

    // record assembly registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q <= '0;
            lo_q  <= '0;
        end else if (byte_valid && !load_start) begin
            if (state_q == S_IDX) idx_q <= byte_in[A-1:0];
            if (state_q == S_LO)  lo_q  <= byte_in;
        end
    end

    // table storage; reset clears to zero offset (hold PC)
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (wr_en) begin
            tbl[idx_q] <= {byte_in[3:0], lo_q};
        end
    end

    // saturating count of entries written this session
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            entry_count <= '0;
        else if (load_start)
            entry_count <= '0;
        else if (wr_en && entry_count != 7'd127)
            entry_count <= entry_count + 7'd1;
    end

    assign target = tbl[addr];

endmodule
